// File: rtl/spi_table_pkg.sv
// spi_table_pkg
//   Shared constants for the SPI forwarding-table command controller:
//   opcode bytes, FSM state encoding, error flag bit positions, fixed tx bytes
//   and the frame-kind enum with a helper that maps it back to its opcode.
package spi_table_pkg;

   // Opcode bytes (first byte of every frame)
   localparam logic [7:0] OP_READ   = 8'h01;
   localparam logic [7:0] OP_WRITE  = 8'h02;
   localparam logic [7:0] OP_INVAL  = 8'h03;
   localparam logic [7:0] OP_STATUS = 8'h04;

   // Byte returned for every payload byte of a WRITE frame
   localparam logic [7:0] WR_ACK = 8'h55;

   // Upper bits of the idle tx byte when any error flag is set
   localparam logic [4:0] IDLE_ERR_PREFIX = 5'b10000;

   // err_flags bit positions: {CSUM, RANGE, BAD_OP}
   localparam int unsigned ERR_BAD_OP = 0;
   localparam int unsigned ERR_RANGE  = 1;
   localparam int unsigned ERR_CSUM   = 2;

   // FSM state encoding
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_INDEX    = 4'd1;
   localparam logic [3:0] ST_RD_LOAD  = 4'd2;
   localparam logic [3:0] ST_RD_CAP   = 4'd3;
   localparam logic [3:0] ST_RD_SHIFT = 4'd4;
   localparam logic [3:0] ST_RD_CSUM  = 4'd5;
   localparam logic [3:0] ST_WR_SHIFT = 4'd6;
   localparam logic [3:0] ST_WR_CSUM  = 4'd7;
   localparam logic [3:0] ST_COMMIT   = 4'd8;
   localparam logic [3:0] ST_STAT     = 4'd9;

   typedef enum logic [1:0] {
      KindRead,
      KindWrite,
      KindInval
   } frame_kind_e;

   // Opcode byte echoed back while a table frame is in its index phase
   function automatic logic [7:0] kind_opcode(input frame_kind_e kind);
      logic [7:0] op;
      case (kind)
         KindWrite: op = OP_WRITE;
         KindInval: op = OP_INVAL;
         default:   op = OP_READ;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter
//   ENTRY_BYTES-wide byte-addressed buffer with a saturating byte counter.
//   Used once as the read-return buffer (parallel load, then advance) and once
//   as the write-assembly buffer (byte-at-a-time fill, LSB byte first).
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clr_i           zero buffer and counter (highest priority)
//   load_i          parallel load load_data_i, counter to 0
//   load_data_i     parallel load value
//   shift_i         write shift_byte_i at byte cnt_o, then advance
//   shift_byte_i    byte written by shift_i
//   adv_i           advance counter without writing
//   buf_o           buffer contents, byte 0 = LSB byte
//   cnt_o           byte counter, saturates at ENTRY_BYTES
module spi_byte_shifter
   import spi_table_pkg::*;
#(
   parameter int unsigned  ENTRY_BYTES = 21,
   localparam int unsigned CNT_W       = $clog2(ENTRY_BYTES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         load_i,
   input  logic [ENTRY_BYTES-1:0][7:0]  load_data_i,
   input  logic                         shift_i,
   input  logic [7:0]                   shift_byte_i,
   input  logic                         adv_i,
   output logic [ENTRY_BYTES-1:0][7:0]  buf_o,
   output logic [CNT_W-1:0]             cnt_o
);

   logic [ENTRY_BYTES-1:0][7:0] buf_q, buf_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        full;

   assign full = (cnt_q == CNT_W'(ENTRY_BYTES));

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (load_i) begin
         buf_d = load_data_i;
         cnt_d = '0;
      end else if ((shift_i || adv_i) && !full) begin
         if (shift_i) begin
            for (int unsigned i = 0; i < ENTRY_BYTES; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  buf_d[i] = shift_byte_i;
               end
            end
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign buf_o = buf_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/spi_table_ctrl.sv
// spi_table_ctrl
//   SPI command controller for the forwarding table. Decodes byte frames
//   (opcode, index, payload) from the SPI slave into table read / write /
//   invalidate operations and returns entries or status on the tx byte.
//   Optional build macro: SPI_TABLE_CTRL_CSUM_EN adds a trailing XOR byte to
//   WRITE/INVAL frames (checked) and to READ frames (generated).
// Ports
//   clk, rst          clock, synchronous active-high reset
//   spi_rx_valid_i    one-cycle strobe, spi_rx_byte_i holds a new byte
//   spi_rx_byte_i     received byte
//   spi_tx_byte_o     byte returned on the next SPI transfer
//   tbl_rd_en_o       table read request pulse; data expected the cycle after
//   tbl_rd_index_o    read index
//   tbl_rd_data_i     table read data
//   tbl_wr_en_o       table write pulse
//   tbl_wr_index_o    write index
//   tbl_wr_data_o     write data
//   busy_o            frame in progress
//   err_flags_o       sticky {CSUM, RANGE, BAD_OP}, cleared by a STATUS frame
module spi_table_ctrl
   import spi_table_pkg::*;
#(
   parameter int unsigned  NUM_ENTRIES = 32,
   parameter int unsigned  ENTRY_WIDTH = 168,
   parameter logic [7:0]   IDLE_TX     = 8'hA5,
   localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES),
   localparam int unsigned ENTRY_BYTES = (ENTRY_WIDTH + 7) / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   spi_rx_valid_i,
   input  logic [7:0]             spi_rx_byte_i,
   output logic [7:0]             spi_tx_byte_o,
   output logic                   tbl_rd_en_o,
   output logic [IDX_W-1:0]       tbl_rd_index_o,
   input  logic [ENTRY_WIDTH-1:0] tbl_rd_data_i,
   output logic                   tbl_wr_en_o,
   output logic [IDX_W-1:0]       tbl_wr_index_o,
   output logic [ENTRY_WIDTH-1:0] tbl_wr_data_o,
   output logic                   busy_o,
   output logic [2:0]             err_flags_o
);

   localparam int unsigned CNT_W = $clog2(ENTRY_BYTES + 1);
   localparam int unsigned BUF_W = ENTRY_BYTES * 8;

   // Where the read / write data phases go once their last entry byte is done
`ifdef SPI_TABLE_CTRL_CSUM_EN
   localparam logic [3:0] RD_AFTER = ST_RD_CSUM;
   localparam logic [3:0] WR_AFTER = ST_WR_CSUM;
`else
   localparam logic [3:0] RD_AFTER = ST_IDLE;
   localparam logic [3:0] WR_AFTER = ST_COMMIT;
`endif

   logic [3:0]       state_q, state_d;
   frame_kind_e      kind_q, kind_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             range_q, range_d;
   logic [2:0]       err_q, err_set, err_clr;
   logic             wr_en_q, wr_en_d;

   logic                        buf_clr, rd_load, rd_adv, wr_shift;
   logic [ENTRY_BYTES-1:0][7:0] rd_buf, wr_buf, rd_load_data;
   logic [CNT_W-1:0]            rd_cnt, wr_cnt;
   logic [BUF_W-1:0]            wr_flat;
   logic [7:0]                  rd_cur;
   logic                        rd_last, wr_last, idx_oob;
   logic                        csum_mismatch, csum_bad;
   logic [7:0]                  rd_csum;

   assign idx_oob = (32'(spi_rx_byte_i) >= NUM_ENTRIES);
   assign rd_last = (rd_cnt == CNT_W'(ENTRY_BYTES - 1));
   assign wr_last = (wr_cnt == CNT_W'(ENTRY_BYTES - 1));

   // Out-of-range reads return an all-zero entry of the normal length
   assign rd_load_data = range_q ? '0 : BUF_W'(tbl_rd_data_i);

   always_comb begin
      rd_cur = 8'h00;
      for (int unsigned i = 0; i < ENTRY_BYTES; i++) begin
         if (rd_cnt == CNT_W'(i)) begin
            rd_cur = rd_buf[i];
         end
      end
   end

   spi_byte_shifter #(
      .ENTRY_BYTES (ENTRY_BYTES)
   ) u_rd_shifter (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (buf_clr),
      .load_i       (rd_load),
      .load_data_i  (rd_load_data),
      .shift_i      (1'b0),
      .shift_byte_i (8'h00),
      .adv_i        (rd_adv),
      .buf_o        (rd_buf),
      .cnt_o        (rd_cnt)
   );

   spi_byte_shifter #(
      .ENTRY_BYTES (ENTRY_BYTES)
   ) u_wr_shifter (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (buf_clr),
      .load_i       (1'b0),
      .load_data_i  ('0),
      .shift_i      (wr_shift),
      .shift_byte_i (spi_rx_byte_i),
      .adv_i        (1'b0),
      .buf_o        (wr_buf),
      .cnt_o        (wr_cnt)
   );

`ifdef SPI_TABLE_CTRL_CSUM_EN
   // Running XOR over index and data bytes of the current frame
   logic [7:0] csum_q, csum_d;
   logic       csum_bad_q;

   always_comb begin
      csum_d = csum_q;
      if (spi_rx_valid_i) begin
         case (state_q)
            ST_IDLE:     csum_d = 8'h00;
            ST_INDEX:    csum_d = spi_rx_byte_i;
            ST_WR_SHIFT: csum_d = csum_q ^ spi_rx_byte_i;
            ST_RD_SHIFT: csum_d = csum_q ^ rd_cur;
            default:     csum_d = csum_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q     <= 8'h00;
         csum_bad_q <= 1'b0;
      end else begin
         csum_q <= csum_d;
         if (state_q == ST_IDLE && spi_rx_valid_i) begin
            csum_bad_q <= 1'b0;
         end else if (csum_mismatch) begin
            csum_bad_q <= 1'b1;
         end
      end
   end

   assign csum_mismatch = (state_q == ST_WR_CSUM) && spi_rx_valid_i &&
                          (spi_rx_byte_i != csum_q);
   assign csum_bad      = csum_bad_q;
   assign rd_csum       = csum_q;
`else
   assign csum_mismatch = 1'b0;
   assign csum_bad      = 1'b0;
   assign rd_csum       = 8'h00;
`endif

   // Frame sequencing
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      idx_d    = idx_q;
      range_d  = range_q;
      err_set  = '0;
      err_clr  = '0;
      buf_clr  = 1'b0;
      rd_load  = 1'b0;
      rd_adv   = 1'b0;
      wr_shift = 1'b0;
      wr_en_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (spi_rx_valid_i) begin
               buf_clr = 1'b1;
               range_d = 1'b0;
               case (spi_rx_byte_i)
                  OP_READ: begin
                     kind_d  = KindRead;
                     state_d = ST_INDEX;
                  end
                  OP_WRITE: begin
                     kind_d  = KindWrite;
                     state_d = ST_INDEX;
                  end
                  OP_INVAL: begin
                     kind_d  = KindInval;
                     state_d = ST_INDEX;
                  end
                  OP_STATUS: state_d = ST_STAT;
                  default:   err_set[ERR_BAD_OP] = 1'b1;
               endcase
            end
         end
         ST_INDEX: begin
            if (spi_rx_valid_i) begin
               idx_d = IDX_W'(spi_rx_byte_i);
               if (idx_oob) begin
                  range_d             = 1'b1;
                  err_set[ERR_RANGE] = 1'b1;
               end
               case (kind_q)
                  KindWrite: state_d = ST_WR_SHIFT;
                  KindInval: state_d = WR_AFTER;
                  default:   state_d = ST_RD_LOAD;
               endcase
            end
         end
         ST_RD_LOAD: state_d = ST_RD_CAP;
         ST_RD_CAP: begin
            rd_load = 1'b1;
            state_d = ST_RD_SHIFT;
         end
         ST_RD_SHIFT: begin
            if (spi_rx_valid_i) begin
               rd_adv = 1'b1;
               if (rd_last) begin
                  state_d = RD_AFTER;
               end
            end
         end
         ST_RD_CSUM: begin
            if (spi_rx_valid_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_SHIFT: begin
            if (spi_rx_valid_i) begin
               wr_shift = 1'b1;
               if (wr_last) begin
                  state_d = WR_AFTER;
               end
            end
         end
         ST_WR_CSUM: begin
            if (spi_rx_valid_i) begin
               err_set[ERR_CSUM] = csum_mismatch;
               state_d           = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // Registered pulse lands two cycles after the final frame strobe
            wr_en_d = !range_q && !csum_bad;
            state_d = ST_IDLE;
         end
         ST_STAT: begin
            if (spi_rx_valid_i) begin
               err_clr = '1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kind_q  <= KindRead;
         idx_q   <= '0;
         range_q <= 1'b0;
         err_q   <= '0;
         wr_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         idx_q   <= idx_d;
         range_q <= range_d;
         // A flag raised in the same cycle as a STATUS clear survives
         err_q   <= (err_q & ~err_clr) | err_set;
         wr_en_q <= wr_en_d;
      end
   end

   // Returned byte, selected from registered state only
   always_comb begin
      spi_tx_byte_o = IDLE_TX;
      case (state_q)
         ST_IDLE:     spi_tx_byte_o = (|err_q) ? {IDLE_ERR_PREFIX, err_q} : IDLE_TX;
         ST_INDEX,
         ST_RD_LOAD,
         ST_RD_CAP:   spi_tx_byte_o = kind_opcode(kind_q);
         ST_RD_SHIFT: spi_tx_byte_o = rd_cur;
         ST_RD_CSUM:  spi_tx_byte_o = rd_csum;
         ST_WR_SHIFT,
         ST_WR_CSUM,
         ST_COMMIT:   spi_tx_byte_o = WR_ACK;
         ST_STAT:     spi_tx_byte_o = {5'b00000, err_q};
         default:     spi_tx_byte_o = IDLE_TX;
      endcase
   end

   assign wr_flat        = wr_buf;
   assign tbl_rd_en_o    = (state_q == ST_RD_LOAD) && !range_q;
   assign tbl_rd_index_o = idx_q;
   assign tbl_wr_en_o    = wr_en_q;
   assign tbl_wr_index_o = idx_q;
   assign tbl_wr_data_o  = wr_flat[ENTRY_WIDTH-1:0];
   assign busy_o         = (state_q != ST_IDLE);
   assign err_flags_o    = err_q;

endmodule

// File: tb/tb_spi_table_ctrl.sv
`timescale 1ns/1ps
module tb_spi_table_ctrl;

   localparam int unsigned NUM_ENTRIES = 32;
   localparam int unsigned ENTRY_WIDTH = 168;
   localparam int unsigned ENTRY_BYTES = 21;
   localparam int unsigned IDX_W       = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   spi_rx_valid;
   logic [7:0]             spi_rx_byte;
   logic [7:0]             spi_tx_byte;
   logic                   tbl_rd_en;
   logic [IDX_W-1:0]       tbl_rd_index;
   logic [ENTRY_WIDTH-1:0] tbl_rd_data;
   logic                   tbl_wr_en;
   logic [IDX_W-1:0]       tbl_wr_index;
   logic [ENTRY_WIDTH-1:0] tbl_wr_data;
   logic                   busy;
   logic [2:0]             err_flags;

   always #5 clk = ~clk;

   spi_table_ctrl #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .ENTRY_WIDTH (ENTRY_WIDTH),
      .IDLE_TX     (8'hA5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .spi_rx_valid_i (spi_rx_valid),
      .spi_rx_byte_i  (spi_rx_byte),
      .spi_tx_byte_o  (spi_tx_byte),
      .tbl_rd_en_o    (tbl_rd_en),
      .tbl_rd_index_o (tbl_rd_index),
      .tbl_rd_data_i  (tbl_rd_data),
      .tbl_wr_en_o    (tbl_wr_en),
      .tbl_wr_index_o (tbl_wr_index),
      .tbl_wr_data_o  (tbl_wr_data),
      .busy_o         (busy),
      .err_flags_o    (err_flags)
   );

   // Table model: one-cycle read latency
   logic [ENTRY_WIDTH-1:0] mem [NUM_ENTRIES];
   always @(posedge clk) begin
      if (tbl_wr_en) mem[tbl_wr_index] <= tbl_wr_data;
      if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_index];
   end

   int                     wr_pulses = 0;
   int                     rd_pulses = 0;
   logic [IDX_W-1:0]       last_wr_idx;
   logic [ENTRY_WIDTH-1:0] last_wr_data;
   always @(negedge clk) begin
      if (tbl_wr_en) begin
         wr_pulses++;
         last_wr_idx  = tbl_wr_index;
         last_wr_data = tbl_wr_data;
      end
      if (tbl_rd_en) rd_pulses++;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [ENTRY_WIDTH-1:0] act,
                        input logic [ENTRY_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Strobe one byte; tx is what the master shifts in during this transfer
   task automatic pulse(input logic [7:0] b, output logic [7:0] tx);
      tx           = spi_tx_byte;
      spi_rx_valid = 1'b1;
      spi_rx_byte  = b;
      @(negedge clk);
      spi_rx_valid = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] b, output logic [7:0] tx);
      pulse(b, tx);
      repeat (3) @(negedge clk);
   endtask

   typedef struct packed {
      logic [7:0] rx;
      logic [7:0] tx_exp;
      logic [2:0] flags_exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0]             tx;
      logic [7:0]             csum;
      int                     bad;
      logic [ENTRY_WIDTH-1:0] exp_entry;
      int                     wr_before;

      // Single-byte frames: bad opcodes, STATUS set/clear
      vecs[0] = '{rx: 8'h7F, tx_exp: 8'hA5, flags_exp: 3'b001};
      vecs[1] = '{rx: 8'h00, tx_exp: 8'h81, flags_exp: 3'b001};
      vecs[2] = '{rx: 8'h04, tx_exp: 8'h81, flags_exp: 3'b001};
      vecs[3] = '{rx: 8'h33, tx_exp: 8'h01, flags_exp: 3'b000};
      vecs[4] = '{rx: 8'h05, tx_exp: 8'hA5, flags_exp: 3'b001};
      vecs[5] = '{rx: 8'hFF, tx_exp: 8'h81, flags_exp: 3'b001};
      vecs[6] = '{rx: 8'h04, tx_exp: 8'h81, flags_exp: 3'b001};
      vecs[7] = '{rx: 8'h00, tx_exp: 8'h01, flags_exp: 3'b000};
      vecs[8] = '{rx: 8'h04, tx_exp: 8'hA5, flags_exp: 3'b000};
      vecs[9] = '{rx: 8'h00, tx_exp: 8'h00, flags_exp: 3'b000};

      for (int k = 0; k < ENTRY_BYTES; k++) exp_entry[8*k +: 8] = 8'(k);

      rst          = 1'b1;
      spi_rx_valid = 1'b0;
      spi_rx_byte  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", ENTRY_WIDTH'(spi_tx_byte), ENTRY_WIDTH'(8'hA5));
      check("rst_busy", ENTRY_WIDTH'(busy), '0);
      check("rst_flags", ENTRY_WIDTH'(err_flags), '0);
      check("rst_wr_en", ENTRY_WIDTH'(tbl_wr_en), '0);
      check("rst_rd_en", ENTRY_WIDTH'(tbl_rd_en), '0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].rx, tx);
         check($sformatf("vec%0d_tx", i), ENTRY_WIDTH'(tx), ENTRY_WIDTH'(vecs[i].tx_exp));
         check($sformatf("vec%0d_flags", i), ENTRY_WIDTH'(err_flags),
               ENTRY_WIDTH'(vecs[i].flags_exp));
      end

      // WRITE idx 5, payload byte k = k
      xfer(8'h02, tx);
      check("wr_op_tx", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'hA5));
      check("wr_busy", ENTRY_WIDTH'(busy), 1);
      xfer(8'h05, tx);
      check("wr_idx_echo", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'h02));
      bad  = 0;
      csum = 8'h05;
      for (int k = 0; k < ENTRY_BYTES - 1; k++) begin
         xfer(8'(k), tx);
         if (tx !== 8'h55) bad++;
         csum = csum ^ 8'(k);
      end
`ifdef SPI_TABLE_CTRL_CSUM_EN
      xfer(8'd20, tx);
      if (tx !== 8'h55) bad++;
      csum = csum ^ 8'd20;
      pulse(csum, tx);
`else
      pulse(8'd20, tx);
`endif
      if (tx !== 8'h55) bad++;
      check("wr_ack_bytes", ENTRY_WIDTH'(bad), '0);
      check("wr_lat_c1", ENTRY_WIDTH'(tbl_wr_en), '0);
      @(negedge clk);
      check("wr_lat_c2", ENTRY_WIDTH'(tbl_wr_en), 1);
      check("wr_index", ENTRY_WIDTH'(tbl_wr_index), ENTRY_WIDTH'(5));
      check("wr_data", tbl_wr_data, exp_entry);
      @(negedge clk);
      check("wr_lat_c3", ENTRY_WIDTH'(tbl_wr_en), '0);
      repeat (2) @(negedge clk);
      check("wr_pulses", ENTRY_WIDTH'(wr_pulses), ENTRY_WIDTH'(1));
      check("wr_busy_end", ENTRY_WIDTH'(busy), '0);

      // READ idx 5 back
      xfer(8'h01, tx);
      pulse(8'h05, tx);
      check("rd_idx_echo", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'h01));
      check("rd_en_lat", ENTRY_WIDTH'(tbl_rd_en), 1);
      check("rd_index", ENTRY_WIDTH'(tbl_rd_index), ENTRY_WIDTH'(5));
      repeat (3) @(negedge clk);
      bad = 0;
      for (int k = 0; k < ENTRY_BYTES; k++) begin
         xfer(8'h00, tx);
         if (tx !== 8'(k)) begin
            bad++;
            $display("FAIL rd_byte%0d: got %h expected %h", k, tx, 8'(k));
         end
      end
      check("rd_bytes", ENTRY_WIDTH'(bad), '0);
`ifdef SPI_TABLE_CTRL_CSUM_EN
      xfer(8'h00, tx);
      check("rd_csum", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'h11));
`endif
      check("rd_idle_tx", ENTRY_WIDTH'(spi_tx_byte), ENTRY_WIDTH'(8'hA5));
      check("rd_pulses", ENTRY_WIDTH'(rd_pulses), ENTRY_WIDTH'(1));

      // WRITE idx 40: range error, no commit
      xfer(8'h02, tx);
      xfer(8'h28, tx);
      csum = 8'h28;
      for (int k = 0; k < ENTRY_BYTES; k++) begin
         xfer(8'hAA, tx);
         csum = csum ^ 8'hAA;
      end
`ifdef SPI_TABLE_CTRL_CSUM_EN
      xfer(csum, tx);
`endif
      repeat (6) @(negedge clk);
      check("range_no_wr", ENTRY_WIDTH'(wr_pulses), ENTRY_WIDTH'(1));
      check("range_idle_tx", ENTRY_WIDTH'(spi_tx_byte), ENTRY_WIDTH'(8'h82));
      xfer(8'h04, tx);
      xfer(8'h00, tx);
      check("range_status", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'h02));
      xfer(8'h04, tx);
      xfer(8'h00, tx);
      check("status_cleared", ENTRY_WIDTH'(tx), '0);

      // INVAL idx 3: all-zero entry committed
      xfer(8'h03, tx);
      xfer(8'h03, tx);
`ifdef SPI_TABLE_CTRL_CSUM_EN
      xfer(8'h03, tx);
`endif
      repeat (4) @(negedge clk);
      check("inval_pulses", ENTRY_WIDTH'(wr_pulses), ENTRY_WIDTH'(2));
      check("inval_index", ENTRY_WIDTH'(last_wr_idx), ENTRY_WIDTH'(3));
      check("inval_data", last_wr_data, '0);

      // Reset mid-WRITE after 10 payload bytes
      xfer(8'h7F, tx);
      xfer(8'h02, tx);
      xfer(8'h07, tx);
      for (int k = 0; k < 10; k++) xfer(8'(k + 100), tx);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_tx", ENTRY_WIDTH'(spi_tx_byte), ENTRY_WIDTH'(8'hA5));
      check("mid_rst_busy", ENTRY_WIDTH'(busy), '0);
      check("mid_rst_flags", ENTRY_WIDTH'(err_flags), '0);
      repeat (30) @(negedge clk);
      check("mid_rst_no_wr", ENTRY_WIDTH'(wr_pulses), ENTRY_WIDTH'(2));

`ifdef SPI_TABLE_CTRL_CSUM_EN
      // WRITE with a corrupted trailing XOR byte
      wr_before = wr_pulses;
      xfer(8'h02, tx);
      xfer(8'h06, tx);
      csum = 8'h06;
      for (int k = 0; k < ENTRY_BYTES; k++) begin
         xfer(8'(k), tx);
         csum = csum ^ 8'(k);
      end
      xfer(csum ^ 8'hFF, tx);
      repeat (6) @(negedge clk);
      check("csum_no_wr", ENTRY_WIDTH'(wr_pulses), ENTRY_WIDTH'(wr_before));
      xfer(8'h04, tx);
      xfer(8'h00, tx);
      check("csum_status", ENTRY_WIDTH'(tx), ENTRY_WIDTH'(8'h04));
`else
      wr_before = wr_pulses;
      check("final_no_wr", ENTRY_WIDTH'(wr_before), ENTRY_WIDTH'(2));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
